// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, shift-subtract
// datapath driven by a three-state start/done controller.
module seq_divider #(
    parameter int dp_width = 5
) (
    input  logic                clock,
    input  logic                reset_b,
    input  logic                start,
    input  logic [dp_width-1:0] dividend,
    input  logic [dp_width-1:0] divisor,
    output logic                ready,
    output logic                done,
    output logic [dp_width-1:0] quotient,
    output logic [dp_width-1:0] remainder,
    output logic                div_by_zero,
    output logic [1:0]          dbg_state_o
);

    // Handshake: start is sampled only on an edge where ready=1 (S_IDLE); the
    // operands are captured on that same edge. done is a one-cycle pulse in
    // S_DONE. The result registers hold until the next accepted start.

    localparam int PW = $clog2(dp_width + 1);
    localparam logic [PW-1:0] P_INIT = PW'(dp_width);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [dp_width:0]   r_q, r_d;
    logic [dp_width-1:0] q_q, q_d;
    logic [dp_width-1:0] b_q, b_d;
    logic [PW-1:0]       p_q, p_d;
    logic [dp_width-1:0] quot_q, quot_d;
    logic [dp_width-1:0] rem_q, rem_d;
    logic                dbz_q, dbz_d;

    logic [2*dp_width:0] rq_shift;
    logic [dp_width:0]   r_shift;
    logic [dp_width+1:0] trial;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            p_q     <= p_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        b_d      = b_q;
        p_d      = p_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        rq_shift = {r_q, q_q} << 1;
        r_shift  = rq_shift[2*dp_width:dp_width];
        // Sign bit of the widened trial subtraction decides the quotient bit.
        trial    = {1'b0, r_shift} - {2'b00, b_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_d     = '0;
                        q_d     = dividend;
                        b_d     = divisor;
                        p_d     = P_INIT;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                r_d = trial[dp_width+1] ? r_shift : trial[dp_width:0];
                q_d = {rq_shift[dp_width-1:1], ~trial[dp_width+1]};
                p_d = p_q - P_ONE;
                if (p_q == P_ONE) begin
                    quot_d  = q_d;
                    rem_d   = r_d[dp_width-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: transaction-level arithmetic model with a result
// queue, per-cycle comparison, and directed literal checks.
module tb_seq_divider;

    localparam int W = 5;

    logic         clock   = 1'b0;
    logic         reset_b = 1'b0;
    logic         start   = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    seq_divider #(.dp_width(W)) dut (
        .clock       (clock),
        .reset_b     (reset_b),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    // Operation-level view: an accepted start either finishes at once (zero
    // divisor) or after W edges; results come from plain / and %.
    int           m_wait = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_quot = '0;
    logic [W-1:0] m_rem  = '0;
    logic         m_dbz  = 1'b0;
    logic [W-1:0] p_quot = '0;
    logic [W-1:0] p_rem  = '0;
    logic         p_dbz  = 1'b0;
    logic [2*W:0] exp_q[$];

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            m_wait = 0;
            m_done = 1'b0;
            m_quot = '0;
            m_rem  = '0;
            m_dbz  = 1'b0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_done = 1'b1;
                m_quot = p_quot;
                m_rem  = p_rem;
                m_dbz  = p_dbz;
            end
        end else if (start) begin
            if (divisor == '0) begin
                p_quot = '1;
                p_rem  = dividend;
                p_dbz  = 1'b1;
            end else begin
                p_quot = dividend / divisor;
                p_rem  = dividend % divisor;
                p_dbz  = 1'b0;
            end
            exp_q.push_back({p_dbz, p_quot, p_rem});
            if (divisor == '0) begin
                m_done = 1'b1;
                m_quot = p_quot;
                m_rem  = p_rem;
                m_dbz  = p_dbz;
            end else begin
                m_dbz  = 1'b0;
                m_wait = W;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clock) begin
        logic [2*W:0] e;
        if (reset_b) begin
            check("ready", ready, (!m_done && m_wait == 0));
            check("done", done, m_done);
            check("quotient_hold", quotient, m_quot);
            check("remainder_hold", remainder, m_rem);
            check("dbz_hold", div_by_zero, m_dbz);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_quotient", quotient, e[2*W-1:W]);
                    check("sb_remainder", remainder, e[W-1:0]);
                    check("sb_dbz", div_by_zero, e[2*W]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int st, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = cyc - st;
                break;
            end
            @(negedge clock);
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int st;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        st       = cyc + 1;
        @(negedge clock);
        start    = 1'b0;
        dividend = W'($urandom_range(0, 31));
        divisor  = W'($urandom_range(0, 31));
        wait_done(st, lat);
    endtask

    task automatic expect_result(input string tag, input int lat, input int exp_lat,
                                 input int q, input int r, input int z);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_quotient"}, quotient, q);
        check({tag, "_remainder"}, remainder, r);
        check({tag, "_dbz"}, div_by_zero, z);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int st;
        int n_done;
        int prev_cyc;
        logic [9:0] pair;

        repeat (3) @(negedge clock);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        #1 reset_b = 1'b1;

        do_op(5'd23, 5'd5, lat);
        expect_result("d23_5", lat, 5, 4, 3, 0);
        do_op(5'd31, 5'd1, lat);
        expect_result("d31_1", lat, 5, 31, 0, 0);
        do_op(5'd3, 5'd31, lat);
        expect_result("d3_31", lat, 5, 0, 3, 0);
        do_op(5'd17, 5'd0, lat);
        expect_result("d17_0", lat, 0, 31, 17, 1);
        do_op(5'd10, 5'd3, lat);
        expect_result("d10_3", lat, 5, 3, 1, 0);

        // start pulsed mid-operation and operands disturbed after capture
        @(negedge clock);
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        st       = cyc + 1;
        @(negedge clock);
        start    = 1'b0;
        dividend = 5'd30;
        divisor  = 5'd2;
        @(negedge clock);
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        dividend = 5'd7;
        divisor  = 5'd0;
        wait_done(st, lat);
        expect_result("ignore_start", lat, 5, 4, 3, 0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("no_extra_done", n_done, 0);

        // reset in the third S_RUN cycle of 29/3
        @(negedge clock);
        dividend = 5'd29;
        divisor  = 5'd3;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset_b = 1'b0;
        #1;
        check("midreset_ready", ready, 1);
        check("midreset_done", done, 0);
        check("midreset_quotient", quotient, 0);
        check("midreset_remainder", remainder, 0);
        check("midreset_dbz", div_by_zero, 0);
        @(negedge clock);
        #1 reset_b = 1'b1;
        do_op(5'd29, 5'd3, lat);
        expect_result("d29_3", lat, 5, 9, 2, 0);

        // exhaustive sweep with start held high
        repeat (2) @(negedge clock);
        pair     = '0;
        dividend = pair[9:5];
        divisor  = pair[4:0];
        start    = 1'b1;
        prev_cyc = -1;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clock);
            wait_done(0, lat);
            if (lat < 0) break;
            if (prev_cyc >= 0)
                check("sweep_spacing", cyc - prev_cyc, (divisor == '0) ? 2 : 7);
            prev_cyc = cyc;
            if (i < 1023) begin
                pair     = 10'(i + 1);
                dividend = pair[9:5];
                divisor  = pair[4:0];
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clock);
        check("sweep_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider: unsigned dividend / divisor -> quotient, remainder.
- One quotient bit per clock, shift-subtract algorithm. It is the inverse operation of the team's shift-add multiplier datapath.
- Sits as a datapath/controller pair behind a start/done handshake. Used by any block needing an integer divide without a combinational array.

Parameters:
- dp_width, 5, operand width in bits. Dividend, divisor, quotient and remainder are all dp_width wide. Legal range 2..32.

Ports:
- clock  input  1  rising-edge clock
- reset_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- dividend  input  dp_width  unsigned dividend, captured on start edge
- divisor  input  dp_width  unsigned divisor, captured on start edge
- ready  output  1  high in S_idle only
- done  output  1  one-cycle pulse, results valid
- quotient  output  dp_width  registered quotient, holds until next start
- remainder  output  dp_width  registered remainder, holds until next start
- div_by_zero  output  1  registered flag for last operation, holds until next start

Behaviour:
- Reset (reset_b=0, async): state=S_idle, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared.
- Internal registers:
  - R: dp_width+1 bits, partial remainder.
  - Q: dp_width bits, shifts in quotient bits.
  - B: divisor copy.
  - P: iteration counter, $clog2(dp_width+1) bits.
- States: S_idle, S_run, S_done.
- S_idle, start=1, divisor!=0:
  - load R=0, Q=dividend, B=divisor, P=dp_width.
  - clear div_by_zero; go to S_run.
- S_idle, start=1, divisor==0:
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - go directly to S_done; no iterations.
- S_idle, start=0: stay; outputs hold.
- S_run, each edge:
  - {R,Q} = {R,Q} << 1.
  - trial T = R_shifted - {1'b0,B} in dp_width+2 bits.
  - if T non-negative: R=T[dp_width:0] and Q[0]=1; else R keeps the shifted value and Q[0]=0.
  - P=P-1.
- On the edge where P goes 1->0: quotient=Q_next, remainder=R_next[dp_width-1:0]; go to S_done.
- Latency: done is high during the cycle after the dp_width-th edge following the start-sampling edge. With zero divisor, done is high during the cycle immediately after the start-sampling edge.
- S_done: done=1 for exactly one cycle; ready=0; next edge unconditionally returns to S_idle.
- start while ready=0 (S_run or S_done): ignored, no queuing. Operands are never re-sampled mid-operation.
- Operand inputs may change freely after the start edge without affecting the result.
- Back-to-back: start held high continuously begins a new operation on the first S_idle edge. Minimum issue interval is dp_width+2 cycles.
- Remainder always < divisor; dividend = quotient*divisor + remainder (divisor!=0).
- Reset asserted mid-operation: immediate return to the reset state. No done pulse, partial results discarded.

Test Plan:
- dp_width=5, dividend=23, divisor=5, start 1 cycle -> done pulses exactly once, 5 edges after the start edge; quotient=4, remainder=3, div_by_zero=0; ready low in between.
- dividend=31, divisor=1 -> quotient=31, remainder=0. Then dividend=3, divisor=31 -> quotient=0, remainder=3.
- dividend=17, divisor=0 -> done in the cycle right after the start edge; quotient=5'b11111, remainder=17, div_by_zero=1. The next valid divide clears div_by_zero.
- Start 23/5, pulse start with 30/2 during S_run, change operand inputs after the start edge -> result still 4 r 3; second start produces no extra done.
- Assert reset_b low on the 3rd S_run cycle of 29/3 -> all outputs 0 and ready=1 immediately. A subsequent 29/3 -> quotient=9, remainder=2.
- Exhaustive sweep over all 1024 operand pairs (dp_width=5) with start held high -> every result matches a reference model; done spacing is exactly 7 cycles (1 cycle for zero-divisor pairs, plus S_idle).
